// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, FSM state type and overflow helper shared by the EX-stage ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W = 6;

  // Encodings inherited from the original MIPS ALU, plus the HI/LO moves.
  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDU  = 6'b000001;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000100;
  localparam logic [OP_W-1:0] OP_SUBU  = 6'b000101;
  localparam logic [OP_W-1:0] OP_MULT  = 6'b000110;
  localparam logic [OP_W-1:0] OP_MULTU = 6'b000111;
  localparam logic [OP_W-1:0] OP_DIV   = 6'b001000;
  localparam logic [OP_W-1:0] OP_DIVU  = 6'b001001;
  localparam logic [OP_W-1:0] OP_AND   = 6'b001010;
  localparam logic [OP_W-1:0] OP_OR    = 6'b001100;
  localparam logic [OP_W-1:0] OP_XOR   = 6'b001110;
  localparam logic [OP_W-1:0] OP_NOR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b010001;
  localparam logic [OP_W-1:0] OP_SLL   = 6'b010010;
  localparam logic [OP_W-1:0] OP_SRL   = 6'b010011;
  localparam logic [OP_W-1:0] OP_SRA   = 6'b010100;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'b101001;
  localparam logic [OP_W-1:0] OP_MFHI  = 6'b110001;
  localparam logic [OP_W-1:0] OP_MFLO  = 6'b110010;
  localparam logic [OP_W-1:0] OP_MTHI  = 6'b110011;
  localparam logic [OP_W-1:0] OP_MTLO  = 6'b110100;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Two's-complement overflow of x+y: same-sign operands, opposite-sign sum.
  // For subtraction pass the inverted sign of the subtrahend.
  function automatic logic signed_ovf(input logic sx, input logic sy, input logic sr);
    return (sx == sy) && (sr != sx);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier / restoring divider on operand magnitudes, sign fixed at output.
// Latency: WIDTH steps after start (one per cycle); results valid combinationally once last has been seen.
// Backpressure: none; start reloads unconditionally, the owner serialises requests.
// Ports: clk, rst_n; start/is_div/is_signed/a/b in; last (final step this cycle), hi/lo/dz out.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic               run, div_q, neg_q, neg_r;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mc, a_q;
  logic [2*WIDTH-1:0] p, p_step, prod_fix;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     madd, rsh;
  logic [WIDTH-1:0]   rsub;
  logic               ge;

  assign a_neg = is_signed && a[WIDTH-1];
  assign b_neg = is_signed && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    madd = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
    rsh  = p[2*WIDTH-1:WIDTH-1];
    ge   = rsh >= {1'b0, mc};
    // When ge holds the difference is below mc, so WIDTH bits are enough.
    rsub = rsh[WIDTH-1:0] - mc;
    if (div_q) begin
      p_step = ge ? {rsub, p[WIDTH-2:0], 1'b1} : {rsh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    end else begin
      p_step = {madd, p[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      a_q   <= '0;
      mc    <= '0;
      p     <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      div_q <= is_div;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dz    <= is_div && (b == '0);
      a_q   <= a;
      mc    <= is_div ? b_mag : a_mag;
      p     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
    end else if (run) begin
      p   <= p_step;
      cnt <= cnt + 1'b1;
      if (last) run <= 1'b0;
    end
  end

  assign last = run && (cnt == CNT_LAST);

  // Sign correction applied to the finished magnitudes; the owner samples these in FIX.
  always_comb begin
    prod_fix = neg_q ? -p : p;
    if (!div_q) begin
      hi = prod_fix[2*WIDTH-1:WIDTH];
      lo = prod_fix[WIDTH-1:0];
    end else if (dz) begin
      hi = a_q;
      lo = '1;
    end else begin
      hi = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      lo = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with registered result, HI/LO registers and iterative mult/div.
// Latency: 1 cycle for simple ops; WIDTH+2 for mult/div (mult 1 cycle when ALU_FAST_MUL_EN is defined).
// Backpressure: result/of/dz held in DONE until out_ready; in_ready low while busy or stalled.
// Ports: clk, rst_n; in_valid/in_ready/op/a/b request side; out_valid/out_ready/result/of/dz
//        response side; hi/lo architectural registers. Optional macro: ALU_FAST_MUL_EN.
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 6,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             of,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import alu_pkg::*;

  state_t             state, state_nxt;
  logic               accept, md_op, md_last, md_dz;
  logic [WIDTH-1:0]   md_hi, md_lo;
  logic [WIDTH-1:0]   sum, diff, s_res, s_hi, s_lo;
  logic               s_of, s_hi_we, s_lo_we;
  logic [SHAMT_W-1:0] shamt;
`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;

  assign md_op = (op == OP_DIV) || (op == OP_DIVU);
`else
  assign md_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = md_op ? CALC : DONE;
      end
      CALC: if (md_last) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        // Draining the result frees the slot for an op in the same cycle.
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? (md_op ? CALC : DONE) : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    shamt   = a[SHAMT_W-1:0];
    s_res   = '0;
    s_of    = 1'b0;
    s_hi    = a;
    s_lo    = a;
    s_hi_we = 1'b0;
    s_lo_we = 1'b0;
`ifdef ALU_FAST_MUL_EN
    prod    = '0;
`endif
    case (op)
      OP_ADD:  begin s_res = sum;  s_of = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]); end
      OP_ADDU: s_res = sum;
      OP_SUB:  begin s_res = diff; s_of = signed_ovf(a[WIDTH-1], ~b[WIDTH-1], diff[WIDTH-1]); end
      OP_SUBU: s_res = diff;
      OP_AND:  s_res = a & b;
      OP_OR:   s_res = a | b;
      OP_XOR:  s_res = a ^ b;
      OP_NOR:  s_res = ~(a | b);
      OP_LUI:  s_res = a << 16;
      OP_SLL:  s_res = b << shamt;
      OP_SRL:  s_res = b >> shamt;
      OP_SRA:  s_res = $unsigned($signed(b) >>> shamt);
      OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: s_res = hi;
      OP_MFLO: s_res = lo;
      OP_MTHI: begin s_res = a; s_hi_we = 1'b1; end
      OP_MTLO: begin s_res = a; s_lo_we = 1'b1; end
`ifdef ALU_FAST_MUL_EN
      OP_MULT, OP_MULTU: begin
        if (op == OP_MULT)
          prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        else
          prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        s_hi    = prod[2*WIDTH-1:WIDTH];
        s_lo    = prod[WIDTH-1:0];
        s_res   = prod[WIDTH-1:0];
        s_hi_we = 1'b1;
        s_lo_we = 1'b1;
      end
`endif
      default: s_res = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && md_op),
    .is_div    ((op == OP_DIV) || (op == OP_DIVU)),
    .is_signed ((op == OP_MULT) || (op == OP_DIV)),
    .a         (a),
    .b         (b),
    .last      (md_last),
    .hi        (md_hi),
    .lo        (md_lo),
    .dz        (md_dz)
  );

  // Results only change on a simple-op accept or on leaving FIX, so DONE holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      of     <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept && !md_op) begin
      result <= s_res;
      of     <= s_of;
      dz     <= 1'b0;
      if (s_hi_we) hi <= s_hi;
      if (s_lo_we) lo <= s_lo;
    end else if (state == FIX) begin
      result <= md_lo;
      of     <= 1'b0;
      dz     <= md_dz;
      hi     <= md_hi;
      lo     <= md_lo;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench for alu_muldiv (WIDTH=32).
// Latency: checked per op against the expected cycle count.
// Backpressure: drives out_ready low for a stall window, otherwise always ready.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [5:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        in_ready, out_valid, of, dz;
  logic [31:0] result, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic        of;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        seen = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;

  alu_muldiv #(.WIDTH(32), .OP_W(6), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .of        (of),
    .dz        (dz),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic, evaluated when the op is accepted.
  task automatic push_exp(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    longint      sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    e.op = o; e.res = '0; e.of = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = cyc;
    case (o)
      6'h00: begin e.res = x + y; e.of = (x[31] == y[31]) && (e.res[31] != x[31]); end
      6'h01: e.res = x + y;
      6'h04: begin e.res = x - y; e.of = (x[31] != y[31]) && (e.res[31] != x[31]); end
      6'h05: e.res = x - y;
      6'h06: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = MUL_LAT; end
      6'h07: begin p = {32'h0, x} * {32'h0, y}; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = MUL_LAT; end
      6'h08, 6'h09: begin
        e.lat = DIV_LAT;
        if (y == 0) begin
          e.dz = 1'b1; m_lo = '1; m_hi = x;
        end else if (o == 6'h08) begin
          p = sx / sy; m_lo = p[31:0];
          p = sx % sy; m_hi = p[31:0];
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
        e.res = m_lo;
      end
      6'h0A: e.res = x & y;
      6'h0C: e.res = x | y;
      6'h0E: e.res = x ^ y;
      6'h10: e.res = ~(x | y);
      6'h11: e.res = x << 16;
      6'h12: e.res = y << x[4:0];
      6'h13: e.res = y >> x[4:0];
      6'h14: e.res = $unsigned($signed(y) >>> x[4:0]);
      6'h26: e.res = (sx < sy) ? 32'd1 : 32'd0;
      6'h29: e.res = (x < y) ? 32'd1 : 32'd0;
      6'h31: e.res = m_hi;
      6'h32: e.res = m_lo;
      6'h33: begin e.res = x; m_hi = x; end
      6'h34: begin e.res = x; m_lo = x; end
      default: e.res = '0;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    sb.push_back(e);
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y, output int waited);
    waited = 0;
    op_i = o; a_i = x; b_i = y; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", in_ready, 1);
        break;
      end
    end
    if (in_ready) push_exp(o, x, y);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: latency at first out_valid, full compare at the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
      sb.delete();
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        if (!seen) begin
          chk($sformatf("latency op%02h", sb[0].op), cyc - sb[0].acc, sb[0].lat);
          seen = 1'b1;
        end
        if (out_ready) begin
          mon_e = sb.pop_front();
          chk($sformatf("result op%02h", mon_e.op), result, mon_e.res);
          chk($sformatf("of op%02h", mon_e.op), of, mon_e.of);
          chk($sformatf("dz op%02h", mon_e.op), dz, mon_e.dz);
          chk($sformatf("hi op%02h", mon_e.op), hi, mon_e.hi);
          chk($sformatf("lo op%02h", mon_e.op), lo, mon_e.lo);
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  logic [5:0] rnd_ops [0:11];

  initial begin
    int w;
    rnd_ops = '{6'h00, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0E, 6'h12, 6'h14, 6'h26, 6'h29, 6'h31};

    #1 rst_n = 1'b0;
    #1;
    chk("rst result", result, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst of", of, 0);
    chk("rst dz", dz, 0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Overflow on add, none on addu; slt/sltu signedness.
    issue(6'h00, 32'h7FFF_FFFF, 32'h1, w);
    issue(6'h01, 32'h7FFF_FFFF, 32'h1, w);
    issue(6'h04, 32'h8000_0000, 32'h1, w);
    issue(6'h26, 32'hFFFF_FFFF, 32'h1, w);
    issue(6'h29, 32'hFFFF_FFFF, 32'h1, w);

    // Iterative unit and HI/LO.
    issue(6'h07, 32'hFFFF_FFFF, 32'h2, w);
    issue(6'h06, 32'hFFFF_FFFD, 32'h5, w);
    issue(6'h08, 32'hFFFF_FFF9, 32'h2, w);
    issue(6'h32, 32'h0, 32'h0, w);
    issue(6'h08, 32'h5, 32'h0, w);
    issue(6'h31, 32'h0, 32'h0, w);
    issue(6'h09, 32'hF000_0000, 32'h7, w);

    // Unknown opcode leaves HI/LO alone; moves and lui.
    issue(6'h3F, 32'h1234, 32'h5678, w);
    issue(6'h33, 32'hCAFE_0001, 32'h0, w);
    issue(6'h34, 32'hBEEF_0002, 32'h0, w);
    issue(6'h31, 32'h0, 32'h0, w);
    issue(6'h32, 32'h0, 32'h0, w);
    issue(6'h11, 32'h0000_ABCD, 32'h0, w);
    drain();

    // Stall with a held result, then a new op in the cycle ready returns.
    out_ready = 1'b0;
    issue(6'h14, 32'h4, 32'h8000_0000, w);
    repeat (5) begin
      @(negedge clk);
      chk("stall out_valid", out_valid, 1);
      chk("stall result", result, 32'hF800_0000);
      chk("stall in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(6'h31, 32'h0, 32'h0, w);
    chk("mfhi accept wait", w, 0);
    drain();

    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? $urandom_range(0, 9) : $urandom;
      issue(rnd_ops[$urandom_range(0, 11)], ra, rb, w);
    end
    drain();

    // Reset in the middle of a divide.
    issue(6'h33, 32'h0000_1234, 32'h0, w);
    issue(6'h34, 32'h0000_5678, 32'h0, w);
    issue(6'h08, 32'd100, 32'd7, w);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("release in_ready", in_ready, 1);
    @(posedge clk); #1;
    issue(6'h01, 32'd5, 32'd7, w);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
